// File: rtl/alu_issue_stage.sv
// ALU decode/issue stage.
// Decodes an RV32I instruction and its register operands into ALU inputs
// (A, B, ALU_FUN, ILLEGAL). The result is held in a registered valid/ready
// slot that has an optional skid entry. Only XLEN = 32 is supported.
module alu_issue_stage #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            FLUSH,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     INSTR,
   input  logic [XLEN-1:0] PC,
   input  logic [XLEN-1:0] RS1_DATA,
   input  logic [XLEN-1:0] RS2_DATA,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] A,
   output logic [XLEN-1:0] B,
   output logic [3:0]      ALU_FUN,
   output logic            ILLEGAL
);

   typedef struct packed {
      logic            illegal;
      logic [3:0]      fun;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } entry_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [3:0] FUN_ADD    = 4'b0000;
   localparam logic [3:0] FUN_COPY_A = 4'b1001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Pure decode: instruction and operands in, ALU entry out.
   // Illegal entries carry zeroed operands and function code.
   function automatic entry_t decode_entry(input logic [31:0]     instr,
                                           input logic [XLEN-1:0] pc,
                                           input logic [XLEN-1:0] rs1,
                                           input logic [XLEN-1:0] rs2);
      entry_t      e;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] imm_i;
      logic [31:0] imm_s;
      logic [31:0] imm_b;
      logic [31:0] imm_u;
      logic [31:0] imm_j;
      f7    = instr[31:25];
      f3    = instr[14:12];
      imm_i = {{20{instr[31]}}, instr[31:20]};
      imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_u = {instr[31:12], 12'b0};
      imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      e     = '0;
      case (instr[6:0])
         OPC_OP: begin
            e.a       = rs1;
            e.b       = rs2;
            e.fun     = {f7[5], f3};
            e.illegal = !((f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_OP_IMM: begin
            e.a = rs1;
            e.b = imm_i;
            if (f3 == 3'b101) begin
               // Shift-right immediates pick logical/arithmetic from f7[5].
               e.fun     = {f7[5], 3'b101};
               e.illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            end else begin
               // No subtract-immediate: f3=000 is always add.
               e.fun     = {1'b0, f3};
               e.illegal = (f3 == 3'b001) && (f7 != F7_BASE);
            end
         end
         OPC_LUI: begin
            e.a   = imm_u;
            e.b   = '0;
            e.fun = FUN_COPY_A;
         end
         OPC_AUIPC: begin
            e.a   = pc;
            e.b   = imm_u;
            e.fun = FUN_ADD;
         end
         OPC_JAL: begin
            e.a   = pc;
            e.b   = imm_j;
            e.fun = FUN_ADD;
         end
         OPC_JALR: begin
            e.a       = rs1;
            e.b       = imm_i;
            e.fun     = FUN_ADD;
            e.illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            // ALU computes the branch target; the compare lives elsewhere.
            e.a       = pc;
            e.b       = imm_b;
            e.fun     = FUN_ADD;
            e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            e.a   = rs1;
            e.b   = imm_i;
            e.fun = FUN_ADD;
         end
         OPC_STORE: begin
            e.a   = rs1;
            e.b   = imm_s;
            e.fun = FUN_ADD;
         end
         default: e.illegal = 1'b1;
      endcase
      if (e.illegal) begin
         e.a   = '0;
         e.b   = '0;
         e.fun = '0;
      end
      return e;
   endfunction

   entry_t dec_p0;
   entry_t main_p1;
   entry_t skid_p1;
   logic   main_vld_p1;
   logic   skid_vld_p1;
   logic   in_fire;
   logic   out_fire;

   // Decode the incoming entry combinationally.
   always_comb begin
      dec_p0 = decode_entry(INSTR, PC, RS1_DATA, RS2_DATA);
   end

   // With the skid entry, ready depends only on registered state. Without it,
   // ready looks through to OUT_READY.
   assign IN_READY = SKID_EN ? !skid_vld_p1 : (!main_vld_p1 || OUT_READY);
   assign in_fire  = IN_VALID && IN_READY;
   assign out_fire = main_vld_p1 && OUT_READY;

   // ---- stage p1: main slot and skid slot ----
   // Main slot refills when it is empty or consumed, from skid first to keep
   // FIFO order; otherwise an accepted entry parks in skid.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (FLUSH) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
      end else if (out_fire || !main_vld_p1) begin
         if (skid_vld_p1) begin
            main_p1     <= skid_p1;
            main_vld_p1 <= 1'b1;
            skid_vld_p1 <= 1'b0;
         end else if (in_fire) begin
            main_p1     <= dec_p0;
            main_vld_p1 <= 1'b1;
         end else begin
            main_vld_p1 <= 1'b0;
         end
      end else if (in_fire && SKID_EN) begin
         skid_p1     <= dec_p0;
         skid_vld_p1 <= 1'b1;
      end
   end

   assign OUT_VALID = main_vld_p1;
   assign A         = main_p1.a;
   assign B         = main_p1.b;
   assign ALU_FUN   = main_p1.fun;
   assign ILLEGAL   = main_p1.illegal;

endmodule
